// File: rtl/figo_room_tracker.sv
// Registers the Figo room controller's proposed room, checks it against the legal ring
// Room0->Room1->Room2->Room3->Room0 and keeps per-room dwell, lap and sticky error status.
module figo_room_tracker #(
  parameter int LAP_W   = 8,
  parameter int DWELL_W = 8,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_en,
  input  logic [2:0]         next_state,
  input  logic               clear_err,
  output logic [2:0]         current_state,
  output logic [3:0]         room_onehot,
  output logic               lap_done,
  output logic [LAP_W-1:0]   lap_count,
  output logic [DWELL_W-1:0] dwell,
  output logic               err_illegal,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    ROOM0 = 3'b000,
    ROOM1 = 3'b001,
    ROOM2 = 3'b010,
    ROOM3 = 3'b011
  } room_t;

  localparam logic [DWELL_W-1:0] DWELL_MAX  = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] TIMEOUT_M1 = DWELL_W'(TIMEOUT - 1);
  localparam logic [LAP_W-1:0]   LAP_MAX    = {LAP_W{1'b1}};
  localparam logic [LAP_W-1:0]   LAP_ONE    = {{(LAP_W-1){1'b0}}, 1'b1};

  room_t              state_r;
  room_t              state_nxt;
  room_t              succ_s;
  logic               advance_s;
  logic               illegal_s;
  logic               lap_s;
  logic               cross_s;
  logic [DWELL_W-1:0] dwell_nxt;

  // Room state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ROOM0;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Successor in the ring and transition classification
  always_comb begin
    succ_s    = ROOM0;
    state_nxt = state_r;
    advance_s = 1'b0;
    illegal_s = 1'b0;
    case (state_r)
      ROOM0:   succ_s = ROOM1;
      ROOM1:   succ_s = ROOM2;
      ROOM2:   succ_s = ROOM3;
      ROOM3:   succ_s = ROOM0;
      default: succ_s = ROOM0;
    endcase
    if (step_en) begin
      if (next_state == state_r) begin
        state_nxt = state_r;
      end else if (next_state == succ_s) begin
        // succ_s[2] is always 0, so codes 4..7 can never match here
        advance_s = 1'b1;
        state_nxt = succ_s;
      end else begin
        illegal_s = 1'b1;
      end
    end else begin
      state_nxt = state_r;
    end
  end

  // Counter next values; an advance suppresses a same-cycle timeout crossing
  always_comb begin
    lap_s     = advance_s && (state_r == ROOM3);
    dwell_nxt = dwell;
    if (advance_s) begin
      dwell_nxt = {DWELL_W{1'b0}};
    end else if (dwell != DWELL_MAX) begin
      dwell_nxt = dwell + DWELL_ONE;
    end else begin
      dwell_nxt = dwell;
    end
    cross_s = !advance_s && (dwell == TIMEOUT_M1);
  end

  // Lap, dwell and sticky error registers; a new set event beats clear_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_done    <= 1'b0;
      lap_count   <= {LAP_W{1'b0}};
      dwell       <= {DWELL_W{1'b0}};
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      lap_done <= lap_s;
      if (lap_s && (lap_count != LAP_MAX)) begin
        lap_count <= lap_count + LAP_ONE;
      end else begin
        lap_count <= lap_count;
      end
      dwell <= dwell_nxt;
      if (illegal_s) begin
        err_illegal <= 1'b1;
      end else if (clear_err) begin
        err_illegal <= 1'b0;
      end else begin
        err_illegal <= err_illegal;
      end
      if (cross_s) begin
        err_timeout <= 1'b1;
      end else if (clear_err) begin
        err_timeout <= 1'b0;
      end else begin
        err_timeout <= err_timeout;
      end
    end
  end

  assign current_state = state_r;

  // One-hot decode of the room register
  always_comb begin
    room_onehot = 4'b0001;
    case (state_r)
      ROOM0:   room_onehot = 4'b0001;
      ROOM1:   room_onehot = 4'b0010;
      ROOM2:   room_onehot = 4'b0100;
      ROOM3:   room_onehot = 4'b1000;
      default: room_onehot = 4'b0001;
    endcase
  end

endmodule

// File: tb/tb_figo_room_tracker.sv
// Scoreboard bench for figo_room_tracker: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry per clock.
module tb_figo_room_tracker;
  localparam int LAP_W   = 2;
  localparam int DWELL_W = 8;
  localparam int TIMEOUT = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               step_en;
  logic [2:0]         next_state;
  logic               clear_err;
  logic [2:0]         current_state;
  logic [3:0]         room_onehot;
  logic               lap_done;
  logic [LAP_W-1:0]   lap_count;
  logic [DWELL_W-1:0] dwell;
  logic               err_illegal;
  logic               err_timeout;

  figo_room_tracker #(.LAP_W(LAP_W), .DWELL_W(DWELL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .next_state(next_state),
    .clear_err(clear_err), .current_state(current_state), .room_onehot(room_onehot),
    .lap_done(lap_done), .lap_count(lap_count), .dwell(dwell),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cur;
    logic       ld;
    logic [1:0] cnt;
    logic [7:0] dw;
    logic       ei;
    logic       et;
    int         id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int vec_id = 0;

  task automatic cyc(input logic en, input logic [2:0] nx, input logic clr,
                     input logic [2:0] c, input logic ld, input logic [1:0] cnt,
                     input logic [7:0] dw, input logic ei, input logic et);
    exp_t e;
    step_en = en; next_state = nx; clear_err = clr;
    e.cur = c; e.ld = ld; e.cnt = cnt; e.dw = dw; e.ei = ei; e.et = et; e.id = vec_id;
    vec_id++;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_vec(input exp_t e);
    logic [3:0] oh;
    oh = 4'b0001 << e.cur[1:0];
    checks++;
    if (current_state !== e.cur || room_onehot !== oh || lap_done !== e.ld ||
        lap_count !== e.cnt || dwell !== e.dw || err_illegal !== e.ei || err_timeout !== e.et) begin
      errors++;
      $display("FAIL vec%0d: got cur=%0d oh=%b ld=%b cnt=%0d dw=%0d ei=%b et=%b, expected cur=%0d oh=%b ld=%b cnt=%0d dw=%0d ei=%b et=%b",
               e.id, current_state, room_onehot, lap_done, lap_count, dwell, err_illegal, err_timeout,
               e.cur, oh, e.ld, e.cnt, e.dw, e.ei, e.et);
    end
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset && lap_done === 1'b1) pulses++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_vec(e);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1; step_en = 1'b0; next_state = 3'd0; clear_err = 1'b0;
    @(negedge clk);
    // reset held: an advance request must be ignored
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    // one full lap
    cyc(1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 2'd1, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 8'd1, 1'b0, 1'b0);
    // illegal backward and out-of-range codes in Room2, then clear
    cyc(1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 2'd1, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 2'd1, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 2'd1, 8'd1, 1'b1, 1'b0);
    cyc(1'b1, 3'd5, 1'b0, 3'd2, 1'b0, 2'd1, 8'd2, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 2'd1, 8'd3, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 2'd1, 8'd4, 1'b0, 1'b0);
    // advance on the would-be timeout edge: no timeout
    cyc(1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 2'd1, 8'd0, 1'b0, 1'b0);
    // clear and illegal in the same cycle: set wins
    cyc(1'b1, 3'd7, 1'b1, 3'd3, 1'b0, 2'd1, 8'd1, 1'b1, 1'b0);
    cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 2'd2, 8'd0, 1'b1, 1'b0);
    cyc(1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 2'd2, 8'd0, 1'b1, 1'b0);
    // hold in Room1 with step_en low until timeout and dwell saturation
    cyc(1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 2'd2, 8'd1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 2'd2, 8'd2, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 2'd2, 8'd3, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 2'd2, 8'd4, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 2'd2, 8'd5, 1'b0, 1'b1);
    for (int d = 6; d <= 257; d++) begin
      cyc(1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 2'd2, (d > 255) ? 8'd255 : 8'(d), 1'b0, 1'b1);
    end
    cyc(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 2'd2, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 2'd2, 8'd1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 2'd2, 8'd2, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 2'd2, 8'd3, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 2'd2, 8'd4, 1'b0, 1'b0);
    // timeout crossing together with clear: set wins
    cyc(1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 2'd2, 8'd5, 1'b0, 1'b1);
    cyc(1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 2'd2, 8'd0, 1'b0, 1'b1);
    // asynchronous reset between clock edges in Room3 with lap_count=2
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (current_state !== 3'd0 || room_onehot !== 4'b0001 || lap_done !== 1'b0 ||
        lap_count !== 2'd0 || dwell !== 8'd0 || err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cur=%0d oh=%b ld=%b cnt=%0d dw=%0d ei=%b et=%b, expected all zero with oh=0001",
               current_state, room_onehot, lap_done, lap_count, dwell, err_illegal, err_timeout);
    end
    @(negedge clk);
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    // five laps with a 2-bit saturating lap counter
    for (int l = 1; l <= 5; l++) begin
      logic [1:0] prev;
      logic [1:0] now;
      prev = (l - 1 > 3) ? 2'd3 : 2'(l - 1);
      now  = (l > 3) ? 2'd3 : 2'(l);
      cyc(1'b1, 3'd1, 1'b0, 3'd1, 1'b0, prev, 8'd0, 1'b0, 1'b0);
      cyc(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, prev, 8'd0, 1'b0, 1'b0);
      cyc(1'b1, 3'd3, 1'b0, 3'd3, 1'b0, prev, 8'd0, 1'b0, 1'b0);
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, now,  8'd0, 1'b0, 1'b0);
    end
    step_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    checks++;
    if (pulses != 7) begin
      errors++;
      $display("FAIL lap_pulses: got %0d, expected 7", pulses);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/figo_room_tracker.md
Name: figo_room_tracker

Overview:
Downstream stage of the Figo room controller. Consumes the controller's combinational next_state and registers it into current_state, which feeds back to the controller. Checks every transition against the legal room ring Room0→Room1→Room2→Room3→Room0. Tracks dwell time per room and completed laps, and raises sticky error and timeout status for the system.

Parameters:
LAP_W, 8, width of the completed-lap counter (saturating)
DWELL_W, 8, width of the dwell-cycle counter (saturating)
TIMEOUT, 200, dwell cycles in one room before a timeout is flagged; must be ≥1 and < 2**DWELL_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
step_en  input  1  when high, next_state is sampled this cycle
next_state  input  3  proposed room from the controller; 3'b000..3'b011 = Room0..Room3, 3'b100..3'b111 illegal
clear_err  input  1  synchronous clear of err_illegal and err_timeout
current_state  output  3  registered room, fed back to the controller
room_onehot  output  4  one-hot decode of current_state (bit n = Room n)
lap_done  output  1  one-cycle pulse on each legal Room3→Room0 move
lap_count  output  LAP_W  completed laps, saturating
dwell  output  DWELL_W  cycles spent in current room since entry, saturating
err_illegal  output  1  sticky: an illegal code or illegal jump was rejected
err_timeout  output  1  sticky: dwell reached TIMEOUT

Behaviour:
- Reset (async assert, sync release) sets the following values:
  - current_state = 3'b000, room_onehot = 4'b0001
  - lap_done = 0, lap_count = 0, dwell = 0
  - err_illegal = 0, err_timeout = 0
- Reset mid-operation abandons all counts immediately; no partial update occurs on the asserting edge.
- All outputs are registered except room_onehot, which is a decode of the current_state register.
- Classification, done only when step_en = 1, with cur = current_state:
  - HOLD: next_state == cur.
  - ADVANCE: next_state == (cur+1) mod 4, with the code in range 0..3.
  - ILLEGAL: next_state[2] = 1, or any other jump (backward, skip by 2).
- step_en = 0 leaves current_state unchanged, with no ADVANCE or ILLEGAL events.
- HOLD: current_state unchanged; dwell increments, saturating at 2**DWELL_W−1.
- ADVANCE: current_state ← next_state on the same edge; dwell ← 0.
  - If cur = 3 and next = 0, lap_done = 1 for exactly that next cycle, and lap_count increments, saturating at 2**LAP_W−1 (lap_done still pulses when saturated).
- ILLEGAL: current_state held; dwell keeps counting as for HOLD; err_illegal ← 1.
- Dwell counting: dwell also increments when step_en = 0. It is reset only by ADVANCE or by reset.
- Timeout: err_timeout ← 1 on the edge where dwell transitions to TIMEOUT. It stays set while dwell continues to saturate.
- Clearing errors:
  - clear_err = 1 clears both error flags on the next edge.
  - If a new ILLEGAL event or timeout crossing happens in the same cycle as clear_err, the set wins and the flag is 1.
  - clear_err does not affect current_state, counters or dwell.
- Simultaneous ADVANCE and a timeout crossing: ADVANCE wins; dwell ← 0 and no timeout is set.
- Latency: one clock from a sampled next_state to the updated current_state, room_onehot and lap_done.
- No other state machine is required beyond the 4-room state register. The 2-bit room index is stored in 3 bits with current_state[2] always 0.

Test Plan:
- Reset, then step_en=1 with next_state 1,2,3,0 on 4 consecutive cycles → current_state 1,2,3,0; lap_done high only in the cycle after the 3→0 edge; lap_count=1; dwell=0 each cycle; no errors.
- From Room2, next_state=3'b000 (backward) then 3'b101 → current_state stays 2; err_illegal=1 after the first; dwell keeps incrementing; clear_err for one cycle → err_illegal=0, current_state still 2.
- TIMEOUT=5, hold in Room1 with step_en=0 → dwell 1..5, err_timeout rises on the edge dwell becomes 5; dwell saturates at 255 after continued hold; ADVANCE to Room2 → dwell=0, err_timeout stays 1.
- LAP_W=2, drive 5 full laps → lap_count 1,2,3,3,3; lap_done pulses 5 times.
- Same cycle: clear_err=1 and illegal next_state=3'b111 → err_illegal remains 1.
- Assert reset asynchronously mid-cycle while in Room3 with lap_count=2 → outputs go to reset values immediately, before the next clock edge; resume from Room0 after release.
